// File: rtl/darkmem_pkg.sv
// darkmem_pkg: shared constants and types for the darkmem load/store unit.
// Holds the RISC-V load/store opcodes, access-size encodings, FSM state
// encodings and completion cause codes used by darkmem_lsu and darkmem_align.
package darkmem_pkg;

  // Major opcodes for loads and stores
  localparam logic [6:0] LCC = 7'b0000011;
  localparam logic [6:0] SCC = 7'b0100011;

  // Access size taken from fct3[1:0]
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  // Sequencer states, kept as plain constants so the encoding is fixed
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  // Completion cause reported on err_cause
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    TIMEOUT  = 2'd2
  } cause_t;

endpackage

// File: rtl/darkmem_align.sv
// darkmem_align: combinational byte-lane steering for darkmem_lsu.
// Produces byte enables, lane-replicated store data, the shifted and
// sign/zero-extended load result, and the misalignment flag for one access.
module darkmem_align
  import darkmem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NBE  = XLEN / 8,
  localparam int LW   = $clog2(NBE)
) (
  input  size_t           i_size,
  input  logic            i_sign,
  input  logic [LW-1:0]   i_lane,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [NBE-1:0]  o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned
);

  logic [NBE-1:0]         w_mask;
  logic [6:0]             w_shamt;
  logic [XLEN-1:0]        w_shifted;
  logic [XLEN-1:0]        w_left;
  logic signed [XLEN-1:0] w_sext;

  // Size decode: lane mask, store replication, extension width and alignment rule
  always_comb begin
    w_mask       = '0;
    o_wdata      = i_wdata;
    w_shamt      = 7'd0;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_mask  = NBE'(1);
        o_wdata = {NBE{i_wdata[7:0]}};
        w_shamt = 7'(XLEN - 8);
      end
      SZ_HALF: begin
        w_mask       = NBE'(3);
        o_wdata      = {(NBE/2){i_wdata[15:0]}};
        w_shamt      = 7'(XLEN - 16);
        o_misaligned = i_lane[0];
      end
      SZ_WORD: begin
        w_mask       = NBE'(15);
        o_wdata      = {(NBE/4){i_wdata[31:0]}};
        w_shamt      = 7'(XLEN - 32);
        o_misaligned = |i_lane[1:0];
      end
      default: begin
        // A doubleword only exists on a 64-bit bus; on 32 bits it can never be aligned
        w_mask       = '1;
        o_wdata      = i_wdata;
        w_shamt      = 7'd0;
        o_misaligned = (XLEN == 64) ? (|i_lane) : 1'b1;
      end
    endcase
  end

  // Byte enables sit at the addressed lane
  assign o_be = w_mask << i_lane;

  // Load path: bring the addressed lane to bit 0, then push the field to the top
  // and shift it back down so the fill bits are either sign copies or zeros
  always_comb begin
    w_shifted = i_rdata >> {i_lane, 3'b000};
    w_left    = w_shifted << w_shamt;
    w_sext    = $signed(w_left) >>> w_shamt;
    o_rdata   = i_sign ? w_sext : (w_left >> w_shamt);
  end

endmodule

// File: rtl/darkmem_lsu.sv
// darkmem_lsu: width-generic load/store unit between the darkriscv execute
// stage and the data bus. One access in flight; the core waits for valid.
// Optional bus watchdog enabled by defining DARKMEM_TIMEOUT_EN; without it
// BUSY waits for bus_valid indefinitely.
module darkmem_lsu
  import darkmem_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int TIMEOUT_CYC = 255,
  localparam int NBE         = XLEN / 8,
  localparam int LW          = $clog2(NBE)
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            en,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data_i,
  output logic            valid,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic [XLEN-1:0] data_o,
  output logic            bus_en,
  output logic            bus_rw,
  output logic [NBE-1:0]  bus_be,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_valid
);

  state_t          r_state;
  logic [2:0]      r_fct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic            r_busEn;
  logic            r_busRw;
  logic            r_valid;
  logic            r_err;
  logic [1:0]      r_cause;
  logic [XLEN-1:0] r_dataO;

`ifdef DARKMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_tmoCnt;
`else
  logic w_unusedTmo;
  assign w_unusedTmo = (TIMEOUT_CYC != 0);
`endif

  logic            w_idle;
  logic            w_isLoad;
  logic            w_isStore;
  logic            w_isMem;
  logic [2:0]      w_fct3;
  logic [LW-1:0]   w_lane;
  logic [NBE-1:0]  w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdataExt;
  logic            w_misaligned;
  logic            w_unusedBits;

  assign w_unusedBits = ^{inst[31:15], inst[11:7]};

  assign w_idle    = (r_state == IDLE);
  assign w_isLoad  = (inst[6:0] == LCC);
  assign w_isStore = (inst[6:0] == SCC);
  assign w_isMem   = w_isLoad | w_isStore;

  // In IDLE the steering logic looks at the live request so alignment can be
  // judged before capture; afterwards it only sees the captured copy, which
  // keeps the bus outputs frozen for the whole access.
  assign w_fct3 = w_idle ? inst[14:12]   : r_fct3;
  assign w_lane = w_idle ? addr[LW-1:0]  : r_addr[LW-1:0];

  darkmem_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_size      (size_t'(w_fct3[1:0])),
    .i_sign      (~w_fct3[2]),
    .i_lane      (w_lane),
    .i_wdata     (r_data),
    .i_rdata     (bus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_rdataExt),
    .o_misaligned(w_misaligned)
  );

  // Sequencer: capture the request, run the bus handshake, post a one-cycle completion
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
      r_fct3  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busEn <= 1'b0;
      r_busRw <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cause <= NONE;
      r_dataO <= '0;
`ifdef DARKMEM_TIMEOUT_EN
      r_tmoCnt <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_fct3 <= inst[14:12];
            r_addr <= addr;
            r_data <= data_i;
            if (w_isMem && !w_misaligned) begin
              r_state <= BUSY;
              r_busEn <= 1'b1;
              r_busRw <= w_isStore;
`ifdef DARKMEM_TIMEOUT_EN
              r_tmoCnt <= '0;
`endif
            end else begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_err   <= w_isMem;
              r_cause <= w_isMem ? MISALIGN : NONE;
            end
          end
        end
        BUSY: begin
          if (bus_valid) begin
            r_busEn <= 1'b0;
            r_busRw <= 1'b0;
            if (!r_busRw) begin
              r_dataO <= w_rdataExt;
            end
            r_state <= DONE;
            r_valid <= 1'b1;
            r_cause <= NONE;
          end
`ifdef DARKMEM_TIMEOUT_EN
          else if (r_tmoCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_busEn <= 1'b0;
            r_busRw <= 1'b0;
            r_state <= DONE;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_cause <= TIMEOUT;
          end else begin
            r_tmoCnt <= r_tmoCnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign valid     = r_valid;
  assign err       = r_err;
  assign err_cause = r_cause;
  assign data_o    = r_dataO;
  assign bus_en    = r_busEn;
  assign bus_rw    = r_busRw;

  // Steered bus fields are only presented while a request is open, so they read
  // zero in reset and disappear together with bus_en
  assign bus_be    = r_busEn ? w_be : '0;
  assign bus_addr  = r_busEn ? {r_addr[XLEN-1:LW], {LW{1'b0}}} : '0;
  assign bus_wdata = r_busEn ? w_wdata : '0;

endmodule
